// File: rtl/if_id_fetch_stage.sv
// Instruction-fetch stage with PC register and IF/ID pipeline register.
// Optional stall-cycle counter enabled by defining FETCH_STALL_CNT_EN.
module if_id_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic        PC_write_i,
  input  logic        IF_ID_write_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic [31:0] instr_i,
  output logic [31:0] pc_o,
  output logic [31:0] IF_ID_pc4_o,
  output logic [31:0] IF_ID_instr_o,
  output logic        IF_ID_valid_o,
  output logic [4:0]  IF_ID_RS_o,
  output logic [4:0]  IF_ID_RT_o,
  output logic [31:0] stall_cnt_o
);

  logic [31:0] pc_r;
  logic [31:0] pc_next_s;
  logic [31:0] pc4_r;
  logic [31:0] pc4_next_s;
  logic [31:0] instr_r;
  logic [31:0] instr_next_s;
  logic        valid_r;
  logic        valid_next_s;
  logic [1:0]  unused_s;

  // Redirect targets are word-aligned, so the low address bits are dropped.
  assign unused_s = redirect_pc_i[1:0];

  // Next PC: redirect beats everything, then start/PC_write gate the increment.
  always_comb begin
    pc_next_s = pc_r;
    if (redirect_i) begin
      pc_next_s = {redirect_pc_i[31:2], 2'b00};
    end else if (!start_i) begin
      pc_next_s = pc_r;
    end else if (!PC_write_i) begin
      pc_next_s = pc_r;
    end else begin
      pc_next_s = pc_r + 32'd4;
    end
  end

  // Next IF/ID contents: flush beats stall, stall beats idle bubble.
  always_comb begin
    pc4_next_s   = pc4_r;
    instr_next_s = instr_r;
    valid_next_s = valid_r;
    if (redirect_i) begin
      pc4_next_s   = 32'h0000_0000;
      instr_next_s = NOP_INSTR;
      valid_next_s = 1'b0;
    end else if (!IF_ID_write_i) begin
      pc4_next_s   = pc4_r;
      instr_next_s = instr_r;
      valid_next_s = valid_r;
    end else if (!start_i) begin
      pc4_next_s   = 32'h0000_0000;
      instr_next_s = NOP_INSTR;
      valid_next_s = 1'b0;
    end else begin
      pc4_next_s   = pc_r + 32'd4;
      instr_next_s = instr_i;
      valid_next_s = 1'b1;
    end
  end

  // PC and IF/ID state registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc_r    <= RESET_PC;
      pc4_r   <= 32'h0000_0000;
      instr_r <= NOP_INSTR;
      valid_r <= 1'b0;
    end else begin
      pc_r    <= pc_next_s;
      pc4_r   <= pc4_next_s;
      instr_r <= instr_next_s;
      valid_r <= valid_next_s;
    end
  end

  assign pc_o          = pc_r;
  assign IF_ID_pc4_o   = pc4_r;
  assign IF_ID_instr_o = instr_r;
  assign IF_ID_valid_o = valid_r;
  assign IF_ID_RS_o    = instr_r[25:21];
  assign IF_ID_RT_o    = instr_r[20:16];

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of cycles where fetch is active but IF/ID is frozen.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_r <= 32'h0000_0000;
    end else if (start_i && !redirect_i && !IF_ID_write_i &&
                 (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt_o = stall_cnt_r;
`else
  assign stall_cnt_o = 32'h0000_0000;
`endif

endmodule

// File: doc/if_id_fetch_stage.md
Name: if_id_fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register for the 5-stage pipelined CPU. Holds the PC, drives the instruction-memory address, and latches {PC+4, instruction} into IF/ID. Consumes the PC_write / IF_ID_write stall controls from the hazard detection unit and the branch/jump redirect from ID. Feeds the IF/ID RS/RT fields back to the hazard detection unit.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word inserted as a bubble on flush or idle

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_n_i  in  1  asynchronous, active-low reset
start_i  in  1  fetch enable; 0 = PC frozen, IF/ID fed bubbles
PC_write_i  in  1  from hazard unit; 0 = hold PC
IF_ID_write_i  in  1  from hazard unit; 0 = hold IF/ID register
redirect_i  in  1  branch taken / jump resolved in ID; flush + redirect
redirect_pc_i  in  32  redirect target address
instr_i  in  32  instruction-memory read data for pc_o (combinational read)
pc_o  out  32  current PC to instruction memory
IF_ID_pc4_o  out  32  latched PC+4
IF_ID_instr_o  out  32  latched instruction
IF_ID_valid_o  out  1  1 = IF/ID holds a real instruction, 0 = bubble
IF_ID_RS_o  out  5  IF_ID_instr_o[25:21], to hazard unit
IF_ID_RT_o  out  5  IF_ID_instr_o[20:16], to hazard unit
stall_cnt_o  out  32  stall-cycle count (see Optional Feature)

Behaviour:
- Reset (rst_n_i=0, asynchronous, takes effect immediately, including mid-stall or mid-redirect): pc_o=RESET_PC, IF_ID_pc4_o=0, IF_ID_instr_o=NOP_INSTR, IF_ID_valid_o=0, stall_cnt_o=0.
- The PC register update uses the following priority, evaluated each rising edge:
  1. redirect_i=1: PC <= {redirect_pc_i[31:2],2'b00}. This applies regardless of PC_write_i and start_i.
  2. start_i=0: PC holds.
  3. PC_write_i=0: PC holds.
  4. Otherwise: PC <= PC+4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- The IF/ID register update uses the following priority, evaluated each rising edge:
  1. redirect_i=1: load bubble {pc4=0, instr=NOP_INSTR, valid=0}. Flush beats stall.
  2. IF_ID_write_i=0: hold all IF/ID fields, including valid.
  3. start_i=0: load bubble.
  4. Otherwise: load {pc_o+4, instr_i, valid=1}.
- Latency: an instruction at address A appears on IF_ID_instr_o 1 cycle after pc_o=A, provided there is no stall or redirect.
- Mismatched controls are legal and handled literally:
  - PC_write_i=0 with IF_ID_write_i=1 re-latches the same instruction.
  - PC_write_i=1 with IF_ID_write_i=0 skips the instruction at the old PC.
- IF_ID_RS_o and IF_ID_RT_o are pure combinational slices of the IF/ID register, with 0 added latency.
- A bubble drives RS=RT=0, so it never matches a real hazard except on $0.
- pc_o is a registered output and never glitches combinationally from the inputs.

Optional Feature:
Macro FETCH_STALL_CNT_EN.
- Defined: stall_cnt_o is a 32-bit counter. It increments on each rising edge where start_i=1, redirect_i=0 and IF_ID_write_i=0.
- The counter saturates at 32'hFFFF_FFFF, with no wrap.
- The counter clears only on reset.
- Not defined: no counter logic is built and stall_cnt_o is tied to 32'h0.

Test Plan:
- Reset release, start_i=1, instr_i = 32'h8C08_0004 at A=0, then 32'h0109_5020 at A=4. Required response:
  - pc_o steps 0→4→8.
  - IF_ID_instr_o shows 8C08_0004 with pc4=4 and valid=1, then 0109_5020 with pc4=8.
  - RS=8 and RT=9 on the second instruction.
- Load-use stall: PC_write_i=IF_ID_write_i=0 for 1 cycle while pc_o=8. Required response:
  - pc_o stays 8 and IF/ID holds the pc4=8 entry for exactly 1 extra cycle, then resumes at pc_o=12.
  - With FETCH_STALL_CNT_EN, stall_cnt_o=1.
- Redirect during stall: redirect_i=1, redirect_pc_i=32'h0000_0043, PC_write_i=IF_ID_write_i=0. Required response:
  - Next cycle pc_o=32'h0000_0040 and IF_ID_valid_o=0, IF_ID_instr_o=0.
  - stall_cnt_o is unchanged.
- Wrap-around: redirect to 32'hFFFF_FFFC, then 1 normal cycle → pc_o=0, and IF_ID_pc4_o=0 with valid=1.
- Async reset asserted mid-cycle while pc_o=32'h20 during a stall. Required response:
  - All outputs take reset values before the next clock edge.
  - After release with start_i=0, pc_o holds RESET_PC and IF_ID_valid_o stays 0.
- start_i dropped for 3 cycles at pc_o=16 → pc_o holds 16, IF/ID loads bubbles, and stall_cnt_o does not increment.
